// File: rtl/gelato_bank_write_scheduler.sv
// gelato_bank_write_scheduler
// Writeback scheduler between the execution units (mem, compute, tensor) and
// the banked register file. Each bank owns one write port and an independent
// round-robin arbiter; the winning writeback is registered onto that bank's
// port one cycle after the valid/ready handshake.
`timescale 1ns/1ps

module gelato_bank_write_scheduler #(
  parameter int REQ_NUM        = 3,
  parameter int BANK_NUM       = 4,
  parameter int WARP_NUM_WIDTH = 5,
  parameter int REG_NUM_WIDTH  = 8,
  parameter int DATA_WIDTH     = 1024
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic                                                     rdy,
  input  logic [REQ_NUM-1:0]                                       req_valid,
  output logic [REQ_NUM-1:0]                                       req_ready,
  input  logic [REQ_NUM*WARP_NUM_WIDTH-1:0]                        req_warp_num,
  input  logic [REQ_NUM*REG_NUM_WIDTH-1:0]                         req_reg_num,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]                            req_data,
  output logic [BANK_NUM-1:0]                                      wr_en,
  output logic [BANK_NUM*WARP_NUM_WIDTH-1:0]                       wr_warp_num,
  output logic [BANK_NUM*(REG_NUM_WIDTH-$clog2(BANK_NUM))-1:0]     wr_reg_num,
  output logic [BANK_NUM*DATA_WIDTH-1:0]                           wr_data
);

  // Low register-index bits select the bank; the remaining bits are the
  // index inside that bank.
  localparam int BANK_BITS = $clog2(BANK_NUM);
  localparam int LOCAL_W   = REG_NUM_WIDTH - BANK_BITS;
  localparam int PTR_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  localparam logic [PTR_W:0]   REQ_NUM_EXT = (PTR_W+1)'(REQ_NUM);
  localparam logic [PTR_W-1:0] LAST_REQ    = PTR_W'(REQ_NUM - 1);

  // Unpacked views of the requester payloads.
  logic [REQ_NUM-1:0][BANK_BITS-1:0]      req_bank;
  logic [REQ_NUM-1:0][LOCAL_W-1:0]        req_local;
  logic [REQ_NUM-1:0][WARP_NUM_WIDTH-1:0] req_warp;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]     req_wdata;

  // Per-bank candidate masks and arbitration results.
  logic [BANK_NUM-1:0][REQ_NUM-1:0]       cand;
  logic [BANK_NUM-1:0]                    win_vld;
  logic [BANK_NUM-1:0][PTR_W-1:0]         win_idx;
  logic [BANK_NUM-1:0]                    xfer;

  // Round-robin pointer per bank: the requester scanned first next time.
  logic [BANK_NUM-1:0][PTR_W-1:0]         rr_ptr;

  // Scan temporaries used only inside the arbitration block.
  logic [PTR_W:0]                         scan_sum;
  logic [PTR_W-1:0]                       scan_idx;

  // Payload selected for each bank from its winning requester.
  logic [BANK_NUM-1:0][WARP_NUM_WIDTH-1:0] sel_warp;
  logic [BANK_NUM-1:0][LOCAL_W-1:0]        sel_local;
  logic [BANK_NUM-1:0][DATA_WIDTH-1:0]     sel_data;

  // Slice the packed requester buses into per-requester fields.
  always_comb begin
    req_bank  = '0;
    req_local = '0;
    req_warp  = '0;
    req_wdata = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      req_bank[r]  = req_reg_num[r*REG_NUM_WIDTH +: BANK_BITS];
      req_local[r] = req_reg_num[r*REG_NUM_WIDTH+BANK_BITS +: LOCAL_W];
      req_warp[r]  = req_warp_num[r*WARP_NUM_WIDTH +: WARP_NUM_WIDTH];
      req_wdata[r] = req_data[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A requester is a candidate for a bank only while valid, so garbage on an
  // idle requester's payload never reaches the arbiters.
  always_comb begin
    cand = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        if (req_valid[r] && (req_bank[r] == BANK_BITS'(b))) begin
          cand[b][r] = 1'b1;
        end
      end
    end
  end

  // Per-bank round-robin: scan from rr_ptr upward modulo REQ_NUM, first
  // candidate found wins.
  always_comb begin
    win_vld  = '0;
    win_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int k = 0; k < REQ_NUM; k++) begin
        scan_sum = {1'b0, rr_ptr[b]} + (PTR_W+1)'(k);
        if (scan_sum >= REQ_NUM_EXT) begin
          scan_sum = scan_sum - REQ_NUM_EXT;
        end
        scan_idx = scan_sum[PTR_W-1:0];
        if (!win_vld[b] && cand[b][scan_idx]) begin
          win_vld[b] = 1'b1;
          win_idx[b] = scan_idx;
        end
      end
    end
  end

  // A bank transfers when its arbiter found a winner and the block is enabled.
  always_comb begin
    xfer = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      xfer[b] = rdy && win_vld[b];
    end
  end

  // Ready goes back to each bank's winner; held low during reset and stall.
  always_comb begin
    req_ready = '0;
    if (rst_n && rdy) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        if (win_vld[b]) begin
          req_ready[win_idx[b]] = 1'b1;
        end
      end
    end
  end

  // Route the winning requester's payload toward each bank's registers.
  always_comb begin
    sel_warp  = '0;
    sel_local = '0;
    sel_data  = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int r = 0; r < REQ_NUM; r++) begin
        if (win_idx[b] == PTR_W'(r)) begin
          sel_warp[b]  = req_warp[r];
          sel_local[b] = req_local[r];
          sel_data[b]  = req_wdata[r];
        end
      end
    end
  end

  // Register the write ports and advance each bank's pointer past its winner;
  // idle or stalled banks drop wr_en but keep payload and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= '0;
      wr_warp_num <= '0;
      wr_reg_num  <= '0;
      wr_data     <= '0;
      rr_ptr      <= '0;
    end else begin
      for (int b = 0; b < BANK_NUM; b++) begin
        if (xfer[b]) begin
          wr_en[b]                                        <= 1'b1;
          wr_warp_num[b*WARP_NUM_WIDTH +: WARP_NUM_WIDTH] <= sel_warp[b];
          wr_reg_num[b*LOCAL_W +: LOCAL_W]                <= sel_local[b];
          wr_data[b*DATA_WIDTH +: DATA_WIDTH]             <= sel_data[b];
          rr_ptr[b] <= (win_idx[b] == LAST_REQ) ? '0 : (win_idx[b] + PTR_W'(1));
        end else begin
          wr_en[b] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gelato_bank_write_scheduler.sv
// Testbench for gelato_bank_write_scheduler: a hand-computed vector table,
// directed multi-cycle sequences, and randomized traffic, all compared against
// a behavioural model of per-bank round-robin writeback scheduling.
`timescale 1ns/1ps

module tb_gelato_bank_write_scheduler;

  localparam int REQ_NUM  = 3;
  localparam int BANK_NUM = 4;
  localparam int WW       = 5;
  localparam int RW       = 8;
  localparam int DW       = 1024;
  localparam int LW       = 6;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    rdy = 1'b0;
  logic [REQ_NUM-1:0]      req_valid = '0;
  logic [REQ_NUM-1:0]      req_ready;
  logic [REQ_NUM*WW-1:0]   req_warp_num = '0;
  logic [REQ_NUM*RW-1:0]   req_reg_num = '0;
  logic [REQ_NUM*DW-1:0]   req_data = '0;
  logic [BANK_NUM-1:0]     wr_en;
  logic [BANK_NUM*WW-1:0]  wr_warp_num;
  logic [BANK_NUM*LW-1:0]  wr_reg_num;
  logic [BANK_NUM*DW-1:0]  wr_data;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int                  m_ptr [BANK_NUM];
  logic [BANK_NUM-1:0] m_en;
  logic [WW-1:0]       m_warp [BANK_NUM];
  logic [LW-1:0]       m_reg  [BANK_NUM];
  logic [DW-1:0]       m_data [BANK_NUM];

  typedef struct {
    logic [2:0]  v;
    logic        r;
    logic [7:0]  g0, g1, g2;
    logic [4:0]  w0, w1, w2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  er;
    logic [3:0]  ee;
  } vec_t;

  vec_t tbl [8];

  gelato_bank_write_scheduler #(
    .REQ_NUM(REQ_NUM), .BANK_NUM(BANK_NUM), .WARP_NUM_WIDTH(WW),
    .REG_NUM_WIDTH(RW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_warp_num(req_warp_num), .req_reg_num(req_reg_num), .req_data(req_data),
    .wr_en(wr_en), .wr_warp_num(wr_warp_num), .wr_reg_num(wr_reg_num), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  task automatic modelReset();
    m_en = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      m_ptr[b]  = 0;
      m_warp[b] = '0;
      m_reg[b]  = '0;
      m_data[b] = '0;
    end
  endtask

  // Winner per bank: first valid requester targeting it, scanning from the
  // bank's pointer around the ring of requesters.
  function automatic logic [REQ_NUM-1:0] modelReady();
    logic [REQ_NUM-1:0] g;
    int r, rg;
    g = '0;
    if (!rdy || !rst_n) return g;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int k = 0; k < REQ_NUM; k++) begin
        r  = (m_ptr[b] + k) % REQ_NUM;
        rg = int'(req_reg_num[r*RW +: RW]);
        if (req_valid[r] && (rg % BANK_NUM) == b) begin
          g[r] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic modelEdge(input logic [REQ_NUM-1:0] g);
    int rg, b;
    m_en = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      if (g[r]) begin
        rg        = int'(req_reg_num[r*RW +: RW]);
        b         = rg % BANK_NUM;
        m_en[b]   = 1'b1;
        m_warp[b] = req_warp_num[r*WW +: WW];
        m_reg[b]  = LW'(rg / BANK_NUM);
        m_data[b] = req_data[r*DW +: DW];
        m_ptr[b]  = (r + 1) % REQ_NUM;
      end
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic r,
                               input logic [7:0] g0, input logic [7:0] g1, input logic [7:0] g2,
                               input logic [4:0] w0, input logic [4:0] w1, input logic [4:0] w2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    req_valid    = v;
    rdy          = r;
    req_reg_num  = {g2, g1, g0};
    req_warp_num = {w2, w1, w0};
    req_data     = {{32{d2}}, {32{d1}}, {32{d0}}};
  endtask

  // One cycle: check ready before the edge, write ports after it.
  task automatic checkCycle(input string tag, input bit use_exp, input logic [2:0] exp_ready,
                            input logic [3:0] exp_en, output logic [2:0] granted);
    logic [2:0] g;
    #1;
    g = modelReady();
    granted = g;
    checkOutput({tag, ".ready"}, DW'(req_ready), DW'(g));
    if (use_exp) checkOutput({tag, ".ready_tbl"}, DW'(req_ready), DW'(exp_ready));
    @(posedge clk);
    modelEdge(g);
    #1;
    checkOutput({tag, ".wr_en"}, DW'(wr_en), DW'(m_en));
    if (use_exp) checkOutput({tag, ".wr_en_tbl"}, DW'(wr_en), DW'(exp_en));
    for (int b = 0; b < BANK_NUM; b++) begin
      checkOutput($sformatf("%s.warp%0d", tag, b), DW'(wr_warp_num[b*WW +: WW]), DW'(m_warp[b]));
      checkOutput($sformatf("%s.reg%0d", tag, b), DW'(wr_reg_num[b*LW +: LW]), DW'(m_reg[b]));
      checkOutput($sformatf("%s.data%0d", tag, b), wr_data[b*DW +: DW], m_data[b]);
    end
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ready"}, DW'(req_ready), DW'(0));
    checkOutput({tag, ".wr_en"}, DW'(wr_en), DW'(0));
    checkOutput({tag, ".warp"}, DW'(wr_warp_num), DW'(0));
    checkOutput({tag, ".reg"}, DW'(wr_reg_num), DW'(0));
    for (int b = 0; b < BANK_NUM; b++)
      checkOutput($sformatf("%s.data%0d", tag, b), wr_data[b*DW +: DW], '0);
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(3'b000, 1'b1, 8'h0, 8'h0, 8'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  logic [2:0]  gr;
  logic [2:0]  cur_v;
  logic [7:0]  cur_g [REQ_NUM];
  logic [4:0]  cur_w [REQ_NUM];
  logic [31:0] cur_d [REQ_NUM];

  initial begin
    // Table: applied in order from reset, all pointers starting at 0.
    tbl[0] = '{3'b010, 1'b1, 8'h00, 8'h0D, 8'h00, 5'd0, 5'd3, 5'd0, 32'h0, 32'hA5A5A5A5, 32'h0, 3'b010, 4'b0010};
    tbl[1] = '{3'b000, 1'b1, 8'h00, 8'h00, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 4'b0000};
    tbl[2] = '{3'b111, 1'b1, 8'h00, 8'h01, 8'h02, 5'd1, 5'd2, 5'd4, 32'h11111111, 32'h22222222, 32'h33333333, 3'b111, 4'b0111};
    tbl[3] = '{3'b111, 1'b1, 8'h04, 8'h08, 8'h0C, 5'd5, 5'd6, 5'd7, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 3'b010, 4'b0001};
    tbl[4] = '{3'b101, 1'b1, 8'h04, 8'h08, 8'h0C, 5'd5, 5'd6, 5'd7, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 3'b100, 4'b0001};
    tbl[5] = '{3'b001, 1'b1, 8'h04, 8'h08, 8'h0C, 5'd5, 5'd6, 5'd7, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 3'b001, 4'b0001};
    tbl[6] = '{3'b111, 1'b0, 8'h03, 8'h07, 8'h0B, 5'd9, 5'd10, 5'd11, 32'hBEEF0000, 32'hBEEF0001, 32'hBEEF0002, 3'b000, 4'b0000};
    tbl[7] = '{3'b111, 1'b1, 8'h03, 8'h07, 8'h0B, 5'd9, 5'd10, 5'd11, 32'hBEEF0000, 32'hBEEF0001, 32'hBEEF0002, 3'b001, 4'b1000};

    // Reset state, with requests presented that must not be granted.
    modelReset();
    applyStimulus(3'b111, 1'b1, 8'h00, 8'h01, 8'h02, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    applyStimulus(3'b000, 1'b1, 8'h0, 8'h0, 8'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].v, tbl[i].r, tbl[i].g0, tbl[i].g1, tbl[i].g2,
                    tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      checkCycle($sformatf("tbl%0d", i), 1'b1, tbl[i].er, tbl[i].ee, gr);
    end

    // Three-way conflict on bank 0, winners drop after their grant.
    doReset();
    applyStimulus(3'b111, 1'b1, 8'h04, 8'h04, 8'h04, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2);
    checkCycle("rr1", 1'b1, 3'b001, 4'b0001, gr);
    req_valid = 3'b110;
    checkCycle("rr2", 1'b1, 3'b010, 4'b0001, gr);
    req_valid = 3'b100;
    checkCycle("rr3", 1'b1, 3'b100, 4'b0001, gr);
    req_valid = 3'b011;
    checkCycle("rr4", 1'b1, 3'b001, 4'b0001, gr);
    req_valid = 3'b000;
    checkCycle("rr5", 1'b1, 3'b000, 4'b0000, gr);

    // Pointer moved past r1 on bank 2: r2 must beat r0.
    doReset();
    applyStimulus(3'b010, 1'b1, 8'h00, 8'h02, 8'h00, 5'd0, 5'd4, 5'd0, 32'h0, 32'hF1, 32'h0);
    checkCycle("fair1", 1'b1, 3'b010, 4'b0100, gr);
    applyStimulus(3'b101, 1'b1, 8'h06, 8'h00, 8'h0A, 5'd8, 5'd0, 5'd9, 32'hF0, 32'h0, 32'hF2);
    checkCycle("fair2", 1'b1, 3'b100, 4'b0100, gr);
    req_valid = 3'b001;
    checkCycle("fair3", 1'b1, 3'b001, 4'b0100, gr);
    req_valid = 3'b000;
    checkCycle("fair4", 1'b1, 3'b000, 4'b0000, gr);

    // Stall: bank 3 payload must hold while rdy is low.
    doReset();
    applyStimulus(3'b010, 1'b1, 8'h00, 8'h03, 8'h00, 5'd0, 5'd7, 5'd0, 32'h0, 32'h5A5A5A5A, 32'h0);
    checkCycle("stall0", 1'b1, 3'b010, 4'b1000, gr);
    applyStimulus(3'b001, 1'b0, 8'h07, 8'h00, 8'h00, 5'd12, 5'd0, 5'd0, 32'h77777777, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkCycle($sformatf("stall%0d", i + 1), 1'b1, 3'b000, 4'b0000, gr);
      checkOutput("stall.hold_warp3", DW'(wr_warp_num[3*WW +: WW]), DW'(5'd7));
    end
    rdy = 1'b1;
    checkCycle("stall5", 1'b1, 3'b001, 4'b1000, gr);
    req_valid = 3'b000;
    checkCycle("stall6", 1'b1, 3'b000, 4'b0000, gr);

    // Asynchronous reset between clock edges while writes are in flight.
    doReset();
    applyStimulus(3'b111, 1'b1, 8'h01, 8'h02, 8'h03, 5'd1, 5'd2, 5'd3, 32'hD1, 32'hD2, 32'hD3);
    @(posedge clk);
    #3;
    checkOutput("midrst.wr_en_before", DW'(wr_en), DW'(4'b1110));
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < BANK_NUM; b++) begin
      applyStimulus(3'b111, 1'b1, 8'(b), 8'(b + 4), 8'(b + 8), 5'd1, 5'd2, 5'd3, 32'hE0, 32'hE1, 32'hE2);
      checkCycle($sformatf("postrst%0d", b), 1'b1, 3'b001, 4'(1 << b), gr);
    end

    // Randomized traffic; requesters hold their payload until granted.
    doReset();
    cur_v = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      cur_g[r] = 8'h0; cur_w[r] = 5'd0; cur_d[r] = 32'h0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < REQ_NUM; r++) begin
        if (!cur_v[r] || gr[r]) begin
          cur_v[r] = ($urandom_range(0, 9) < 6);
          cur_g[r] = 8'($urandom);
          cur_w[r] = 5'($urandom);
          cur_d[r] = $urandom;
        end
      end
      applyStimulus(cur_v, ($urandom_range(0, 7) != 0), cur_g[0], cur_g[1], cur_g[2],
                    cur_w[0], cur_w[1], cur_w[2], cur_d[0], cur_d[1], cur_d[2]);
      checkCycle("rand", 1'b0, 3'b000, 4'b0000, gr);
    end
    if (c_dummy_unused()) ;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic bit c_dummy_unused();
    return 1'b0;
  endfunction

  initial gr = '0;

endmodule
